// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - video timing constants, bank index and sync types for fb_scanout
package fb_pkg;

  localparam int H_TOTAL  = 384;
  localparam int H_ACTIVE = 256;
  localparam int HS_START = 288;
  localparam int HS_END   = 319;
  localparam int V_TOTAL  = 264;
  localparam int V_ACTIVE = 224;
  localparam int VS_START = 240;
  localparam int VS_END   = 243;
  localparam int V_OFFSET = 16;

  typedef logic [1:0] bank_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic hb;
    logic vb;
  } sync_t;

  function automatic logic [7:0] expand3(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  function automatic logic [7:0] expand2(input logic [1:0] c);
    return {c, c, c, c};
  endfunction

endpackage

// File: rtl/fb_scanout_if.sv
// rtl/fb_scanout_if.sv - renderer pixel-write bus into the frame buffer
interface fb_scanout_if;
  logic [7:0] h;
  logic [7:0] v;
  logic [2:0] r;
  logic [2:0] g;
  logic [1:0] b;
  logic       done;
  logic       frame;

  modport master (output h, v, r, g, b, done, frame);
  modport slave  (input  h, v, r, g, b, done, frame);
endinterface

// File: rtl/fb_bank_ram.sv
// rtl/fb_bank_ram.sv - 64Kx8 simple dual-port bank, registered read
module fb_bank_ram (
  input  logic        clk,
  input  logic        we,
  input  logic [15:0] waddr,
  input  logic [7:0]  wdata,
  input  logic        re,
  input  logic [15:0] raddr,
  output logic [7:0]  rdata
);

  logic [7:0] mem [0:65535];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fb_scanout.sv
// rtl/fb_scanout.sv - frame-buffer sink with tear-free bank swap and raster scanout
// Define FB_TRIPLE_EN for triple buffering; the default build is double-buffered.
module fb_scanout
  import fb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  fb_scanout_if.slave px,
  output logic [7:0]  vid_r,
  output logic [7:0]  vid_g,
  output logic [7:0]  vid_b,
  output logic        hsync,
  output logic        vsync,
  output logic        hblank,
  output logic        vblank,
  output bank_t       disp_bank
);

`ifdef FB_TRIPLE_EN
  localparam int N_BANKS = 3;
`else
  localparam int N_BANKS = 2;
`endif

  logic [8:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic        swap_pt;
  sync_t       s1_sync_q, s1_sync_d, s2_sync_q, s2_sync_d;
  logic        s1_gate_q, s1_gate_d, s2_gate_q, s2_gate_d;
  logic [15:0] s1_addr_q, s1_addr_d;
  bank_t       wr_bank_q, wr_bank_d, disp_q, disp_d, sel_q, sel_d;
  logic [7:0]  rd_data [N_BANKS];
  logic [7:0]  pix;

  always_comb begin
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    swap_pt   = 1'b0;
    s1_sync_d = s1_sync_q;
    s1_gate_d = s1_gate_q;
    s1_addr_d = s1_addr_q;
    s2_sync_d = s2_sync_q;
    s2_gate_d = s2_gate_q;
    sel_d     = sel_q;
    if (ce_pix) begin
      if (hcnt_q == 9'(H_TOTAL - 1)) begin
        hcnt_d  = '0;
        vcnt_d  = (vcnt_q == 9'(V_TOTAL - 1)) ? '0 : vcnt_q + 9'd1;
        swap_pt = (vcnt_q == 9'(V_ACTIVE - 1));
      end else begin
        hcnt_d = hcnt_q + 9'd1;
      end
      s1_sync_d.hs = (hcnt_q >= 9'(HS_START)) && (hcnt_q <= 9'(HS_END));
      s1_sync_d.vs = (vcnt_q >= 9'(VS_START)) && (vcnt_q <= 9'(VS_END));
      s1_sync_d.hb = (hcnt_q >= 9'(H_ACTIVE));
      s1_sync_d.vb = (vcnt_q >= 9'(V_ACTIVE));
      s1_gate_d    = s1_sync_d.hb | s1_sync_d.vb;
      s1_addr_d    = {vcnt_q[7:0] + 8'(V_OFFSET), hcnt_q[7:0]};
      // Bank select travels with the RAM read so colour and bank stay paired.
      s2_sync_d = s1_sync_q;
      s2_gate_d = s1_gate_q;
      sel_d     = disp_q;
    end
  end

`ifdef FB_TRIPLE_EN
  // The spare bank is "ready" when rdy is set, otherwise it is free.
  bank_t spare_q, spare_d;
  logic  rdy_q, rdy_d;

  always_comb begin
    wr_bank_d = wr_bank_q;
    disp_d    = disp_q;
    spare_d   = spare_q;
    rdy_d     = rdy_q;
    if (px.frame) begin
      wr_bank_d = spare_q;
      spare_d   = wr_bank_q;
      rdy_d     = 1'b1;
    end
    if (swap_pt && rdy_d) begin
      disp_d  = spare_d;
      spare_d = disp_q;
      rdy_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spare_q <= 2'd2;
      rdy_q   <= 1'b0;
    end else begin
      spare_q <= spare_d;
      rdy_q   <= rdy_d;
    end
  end
`else
  logic pending_q, pending_d;

  always_comb begin
    wr_bank_d = wr_bank_q;
    disp_d    = disp_q;
    pending_d = pending_q | px.frame;
    if (swap_pt && pending_d) begin
      wr_bank_d = disp_q;
      disp_d    = wr_bank_q;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pending_q <= 1'b0;
    else       pending_q <= pending_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      s1_sync_q <= '0;
      s1_gate_q <= 1'b1;
      s1_addr_q <= '0;
      s2_sync_q <= '0;
      s2_gate_q <= 1'b1;
      sel_q     <= 2'd1;
      wr_bank_q <= 2'd0;
      disp_q    <= 2'd1;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      s1_sync_q <= s1_sync_d;
      s1_gate_q <= s1_gate_d;
      s1_addr_q <= s1_addr_d;
      s2_sync_q <= s2_sync_d;
      s2_gate_q <= s2_gate_d;
      sel_q     <= sel_d;
      wr_bank_q <= wr_bank_d;
      disp_q    <= disp_d;
    end
  end

  for (genvar i = 0; i < N_BANKS; i++) begin : g_bank
    fb_bank_ram u_ram (
      .clk   (clk),
      .we    (px.done && (wr_bank_q == bank_t'(i))),
      .waddr ({px.v, px.h}),
      .wdata ({px.b, px.g, px.r}),
      .re    (ce_pix),
      .raddr (s1_addr_q),
      .rdata (rd_data[i])
    );
  end

  always_comb begin
    pix = '0;
    for (int i = 0; i < N_BANKS; i++) begin
      if (sel_q == bank_t'(i)) pix = rd_data[i];
    end
  end

  // s2_gate starts high out of reset so stale RAM data never reaches the outputs.
  assign vid_r     = s2_gate_q ? 8'd0 : expand3(pix[2:0]);
  assign vid_g     = s2_gate_q ? 8'd0 : expand3(pix[5:3]);
  assign vid_b     = s2_gate_q ? 8'd0 : expand2(pix[7:6]);
  assign hsync     = s2_sync_q.hs;
  assign vsync     = s2_sync_q.vs;
  assign hblank    = s2_sync_q.hb;
  assign vblank    = s2_sync_q.vb;
  assign disp_bank = disp_q;

endmodule

// File: tb/tb_fb_scanout.sv
// tb/tb_fb_scanout.sv - directed bench for fb_scanout timing, colour path and bank swaps
module tb_fb_scanout;

  localparam int FRAME = 384 * 264;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce_pix;
  logic [7:0] vid_r, vid_g, vid_b;
  logic       hsync, vsync, hblank, vblank;
  logic [1:0] disp_bank;

  fb_scanout_if px ();

  fb_scanout dut (
    .clk       (clk),
    .reset     (reset),
    .ce_pix    (ce_pix),
    .px        (px),
    .vid_r     (vid_r),
    .vid_g     (vid_g),
    .vid_b     (vid_b),
    .hsync     (hsync),
    .vsync     (vsync),
    .hblank    (hblank),
    .vblank    (vblank),
    .disp_bank (disp_bank)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int hc, vc, h1, v1, h2, v2, nsteps;
  int hs_tot, vs_tot, hb_tot, vb_tot;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (v=%0d h=%0d)", tag, got, exp, vc, hc);
    end
  endtask

  task automatic reset_dut();
    reset  = 1'b1;
    ce_pix = 1'b0;
    px.done  = 1'b0;
    px.frame = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    hc = 0; vc = 0; h1 = 0; v1 = 0; h2 = 0; v2 = 0; nsteps = 0;
    hs_tot = 0; vs_tot = 0; hb_tot = 0; vb_tot = 0;
  endtask

  task automatic wr_px(input logic [7:0] vv, input logic [7:0] hh, input logic [7:0] d);
    ce_pix  = 1'b0;
    px.v    = vv;
    px.h    = hh;
    px.b    = d[7:6];
    px.g    = d[5:3];
    px.r    = d[2:0];
    px.done = 1'b1;
    @(posedge clk);
    #1;
    px.done = 1'b0;
  endtask

  task automatic pulse_frame();
    ce_pix   = 1'b0;
    px.frame = 1'b1;
    @(posedge clk);
    #1;
    px.frame = 1'b0;
  endtask

  // One ce_pix step; outputs after it must reflect the counter two steps back.
  task automatic step();
    logic [3:0] exp_f;
    ce_pix = 1'b1;
    @(posedge clk);
    #1;
    ce_pix = 1'b0;
    h2 = h1; v2 = v1; h1 = hc; v1 = vc;
    if (hc == 383) begin
      hc = 0;
      vc = (vc == 263) ? 0 : vc + 1;
    end else begin
      hc = hc + 1;
    end
    nsteps++;
    if (nsteps >= 2) begin
      exp_f = {(h2 >= 288 && h2 <= 319), (v2 >= 240 && v2 <= 243), (h2 >= 256), (v2 >= 224)};
      hs_tot += int'(hsync);
      vs_tot += int'(vsync);
      hb_tot += int'(hblank);
      vb_tot += int'(vblank);
      if (h2 == 0 || h2 == 255 || h2 == 256 || h2 == 287 || h2 == 288 ||
          h2 == 319 || h2 == 320 || h2 == 383) begin
        check("sync_blank", {28'd0, hsync, vsync, hblank, vblank}, {28'd0, exp_f});
        if (exp_f[1] || exp_f[0]) check("blank_rgb", {8'd0, vid_r, vid_g, vid_b}, 32'd0);
      end
    end
    if (nsteps == FRAME + 1) begin
      check("hsync_steps", hs_tot, 32'd8448);
      check("vsync_steps", vs_tot, 32'd1536);
      check("hblank_steps", hb_tot, 32'd33792);
      check("vblank_steps", vb_tot, 32'd15360);
    end
  endtask

  task automatic run_to(input int vt, input int ht);
    while (!(vc == vt && hc == ht)) step();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rgb"}, {8'd0, vid_r, vid_g, vid_b}, 32'd0);
    check({tag, "_sync"}, {28'd0, hsync, vsync, hblank, vblank}, 32'd0);
    check({tag, "_disp"}, {30'd0, disp_bank}, 32'd1);
  endtask

  initial begin
    px.h = '0; px.v = '0; px.r = '0; px.g = '0; px.b = '0;
    reset_dut();
    check_reset_state("reset");

`ifdef FB_TRIPLE_EN
    wr_px(8'd16, 8'd0, 8'hFF);
    pulse_frame();
    wr_px(8'd16, 8'd0, 8'h63);
    pulse_frame();
    wr_px(8'd16, 8'd0, 8'h24);
    run_to(223, 383);
    check("tri_disp_pre", {30'd0, disp_bank}, 32'd1);
    step();
    check("tri_disp_swap", {30'd0, disp_bank}, 32'd2);
    run_to(0, 2);
    check("tri_second_shown", {8'd0, vid_r, vid_g, vid_b}, 32'h6D9255);
    run_to(223, 383);
    step();
    check("tri_no_reswap", {30'd0, disp_bank}, 32'd2);
`else
    wr_px(8'd16, 8'd0, 8'hFF);
    wr_px(8'd20, 8'd5, 8'h63);
    px.frame = 1'b1;
    step();
    px.frame = 1'b0;
    wr_px(8'd17, 8'd3, 8'h24);
    run_to(10, 0);
    px.frame = 1'b1;
    step();
    px.frame = 1'b0;
    run_to(223, 383);
    check("disp_pre_swap", {30'd0, disp_bank}, 32'd1);
    step();
    check("disp_swap", {30'd0, disp_bank}, 32'd0);

    run_to(0, 2);
    check("px_ff", {8'd0, vid_r, vid_g, vid_b}, 32'hFFFFFF);
    run_to(1, 5);
    check("px_pending_wr", {8'd0, vid_r, vid_g, vid_b}, 32'h929200);
    run_to(4, 7);
    check("px_expand", {8'd0, vid_r, vid_g, vid_b}, 32'h6D9255);
    run_to(4, 263);
    check("px_hblank_rgb", {8'd0, vid_r, vid_g, vid_b}, 32'd0);
    check("px_hblank_flag", {31'd0, hblank}, 32'd1);

    run_to(223, 383);
    px.frame = 1'b1;
    step();
    px.frame = 1'b0;
    check("frame_at_swap", {30'd0, disp_bank}, 32'd1);

    run_to(223, 383);
    step();
    check("no_swap_after_sp", {30'd0, disp_bank}, 32'd1);

    px.frame = 1'b1;
    step();
    px.frame = 1'b0;
    repeat (20) step();
    reset_dut();
    check_reset_state("midreset");
    run_to(223, 383);
    step();
    check("reset_drops_pending", {30'd0, disp_bank}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
